// File: rtl/axi_wr_chan_buf.sv
// Single-clock buffer for the AXI write channels: three FWFT FIFOs (AW, W, B)
// plus an outstanding-write counter that throttles AW and a sticky B-underflow flag.

module axi_wr_chan_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [W-1:0]             w_data,
    input  logic                     rd_en,
    input  logic                     push_en,
    output logic                     not_empty,
    output logic                     not_full,
    output logic [W-1:0]             r_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] ONE = (IW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [IW:0]  wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
    logic         empty, full, push, pop;

    // Pointers carry an extra wrap bit: equal index with differing wrap bit means full.
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);
    assign not_empty = ~empty;
    assign not_full  = ~full & push_en;
    assign push      = wr_en & not_full & ~flush;
    assign pop       = rd_en & ~empty & ~flush;
    assign count     = cnt_q;
    // Head is read combinationally; an empty FIFO presents zero so stale data never shows.
    assign r_data    = empty ? '0 : mem_q[rptr_q[IW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + ONE;
            if (pop)  rptr_d = rptr_q + ONE;
            if (push && !pop)      cnt_d = cnt_q + ONE;
            else if (pop && !push) cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[IW-1:0]] <= w_data;
    end
endmodule

module axi_wr_chan_buf #(
    parameter int AW_W     = 49,
    parameter int W_W      = 37,
    parameter int B_W      = 10,
    parameter int AW_DEPTH = 4,
    parameter int W_DEPTH  = 8,
    parameter int B_DEPTH  = 4,
    parameter int MAX_OUT  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          AW_wr_en,
    input  logic [AW_W-1:0]               AW_w_data,
    input  logic                          AW_rd_en,
    output logic                          AW_not_empty,
    output logic                          AW_not_full,
    output logic [AW_W-1:0]               AW_r_data,
    output logic [$clog2(AW_DEPTH):0]     AW_count,
    input  logic                          W_wr_en,
    input  logic [W_W-1:0]                W_w_data,
    input  logic                          W_rd_en,
    output logic                          W_not_empty,
    output logic                          W_not_full,
    output logic [W_W-1:0]                W_r_data,
    output logic [$clog2(W_DEPTH):0]      W_count,
    input  logic                          B_wr_en,
    input  logic [B_W-1:0]                B_w_data,
    input  logic                          B_rd_en,
    output logic                          B_not_empty,
    output logic                          B_not_full,
    output logic [B_W-1:0]                B_r_data,
    output logic [$clog2(B_DEPTH):0]      B_count,
    output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
    output logic                          b_underflow
);
    localparam int OW = $clog2(MAX_OUT+1);
    localparam logic [OW-1:0] OUT_ONE = OW'(1);

    logic [OW-1:0] out_q, out_d;
    logic          uf_q, uf_d, aw_gate, aw_push, b_pop;

    assign aw_gate     = (out_q < OW'(MAX_OUT));
    assign aw_push     = AW_wr_en & AW_not_full & ~flush;
    assign b_pop       = B_rd_en & B_not_empty & ~flush;
    assign outstanding = out_q;
    assign b_underflow = uf_q;

    axi_wr_chan_fifo #(.W(AW_W), .DEPTH(AW_DEPTH)) u_aw (
        .clk(clk), .rst_n(rst), .flush(flush),
        .wr_en(AW_wr_en), .w_data(AW_w_data), .rd_en(AW_rd_en), .push_en(aw_gate),
        .not_empty(AW_not_empty), .not_full(AW_not_full), .r_data(AW_r_data), .count(AW_count)
    );

    axi_wr_chan_fifo #(.W(W_W), .DEPTH(W_DEPTH)) u_w (
        .clk(clk), .rst_n(rst), .flush(flush),
        .wr_en(W_wr_en), .w_data(W_w_data), .rd_en(W_rd_en), .push_en(1'b1),
        .not_empty(W_not_empty), .not_full(W_not_full), .r_data(W_r_data), .count(W_count)
    );

    axi_wr_chan_fifo #(.W(B_W), .DEPTH(B_DEPTH)) u_b (
        .clk(clk), .rst_n(rst), .flush(flush),
        .wr_en(B_wr_en), .w_data(B_w_data), .rd_en(B_rd_en), .push_en(1'b1),
        .not_empty(B_not_empty), .not_full(B_not_full), .r_data(B_r_data), .count(B_count)
    );

    // A B pop with nothing outstanding saturates at zero and latches the error.
    always_comb begin
        out_d = out_q;
        uf_d  = uf_q;
        if (flush) begin
            out_d = '0;
            uf_d  = 1'b0;
        end else begin
            if (aw_push && !b_pop)                     out_d = out_q + OUT_ONE;
            else if (!aw_push && b_pop && out_q != '0) out_d = out_q - OUT_ONE;
            if (b_pop && out_q == '0) uf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            uf_q  <= uf_d;
        end
    end
endmodule
